imm_gen_stage: RTL and testbench

IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

---
 rtl/imm_gen_stage.sv | 114 +++++++++++
 tb/tb_imm_gen_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// LEGv8 immediate generation stage: decodes format and extended immediate
// at the input and buffers entries in a 2-deep in-order skid FIFO.
module imm_gen_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_D  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_CB = 3'd4;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    entry_t     head_q, head_d;
    entry_t     tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;
    entry_t     new_e;
    logic       accept;
    logic       pop;

    // Decode order matters: earlier opcode classes win.
    always_comb begin
        new_e       = '0;
        new_e.instr = in_instr;
        new_e.pc    = in_pc;
        if (in_instr[31:21] == 11'h7C2 || in_instr[31:21] == 11'h7C0) begin
            new_e.fmt = FMT_D;
            new_e.imm = {{(XLEN-9){in_instr[20]}}, in_instr[20:12]};
        end else if (in_instr[31:22] == 10'h244 ||
                     in_instr[31:22] == 10'h344) begin
            new_e.fmt = FMT_I;
            new_e.imm = {{(XLEN-12){1'b0}}, in_instr[21:10]};
        end else if (in_instr[31:26] == 6'h05) begin
            new_e.fmt = FMT_B;
            new_e.imm = {{(XLEN-28){in_instr[25]}}, in_instr[25:0], 2'b00};
        end else if (in_instr[31:24] == 8'hB4 ||
                     in_instr[31:24] == 8'hB5 ||
                     in_instr[31:24] == 8'h54) begin
            new_e.fmt = FMT_CB;
            new_e.imm = {{(XLEN-21){in_instr[23]}}, in_instr[23:5], 2'b00};
        end else begin
            new_e.fmt = FMT_R;
            new_e.imm = '0;
        end
    end

    assign in_ready  = (cnt_q < 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign accept    = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else if (accept && pop) begin
            // only reachable at count 1: new entry replaces the head
            head_d = new_e;
        end else if (pop) begin
            if (cnt_q == 2'd2) begin
                head_d = tail_q;
            end
            cnt_d = cnt_q - 2'd1;
        end else if (accept) begin
            if (cnt_q == 2'd0) begin
                head_d = new_e;
            end else begin
                tail_d = new_e;
            end
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Stale head data is masked so an empty stage reads all-zero.
    assign out_imm   = out_valid ? head_q.imm   : '0;
    assign out_fmt   = out_valid ? head_q.fmt   : 3'd0;
    assign out_instr = out_valid ? head_q.instr : 32'd0;
    assign out_pc    = out_valid ? head_q.pc    : '0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: decode table plus FIFO, flush and
// asynchronous reset sequences.
module tb_imm_gen_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_stage #(.XLEN(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_fmt   (out_fmt),
        .out_instr (out_instr),
        .out_pc    (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [2:0]  fmt;
        logic [63:0] imm;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [63:0] pc);
        @(negedge clk);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_empty(input string name);
        chk({name, ".valid"}, 64'(out_valid), 64'd0);
        chk({name, ".ready"}, 64'(in_ready), 64'd1);
        chk({name, ".imm"}, out_imm, 64'd0);
        chk({name, ".fmt"}, 64'(out_fmt), 64'd0);
        chk({name, ".instr"}, 64'(out_instr), 64'd0);
        chk({name, ".pc"}, out_pc, 64'd0);
    endtask

    localparam logic [31:0] IA = 32'hF85F0000;
    localparam logic [31:0] IB = 32'h913FFC00;
    localparam logic [31:0] IC = 32'hB4000020;
    localparam logic [31:0] ID = 32'h17FFFFFF;

    initial begin
        tbl[0] = '{32'hF85F0000, 64'h1000, 3'd2, 64'hFFFFFFFFFFFFFFF0};
        tbl[1] = '{32'hF80FF000, 64'h1004, 3'd2, 64'h00000000000000FF};
        tbl[2] = '{32'h913FFC00, 64'h1008, 3'd1, 64'h0000000000000FFF};
        tbl[3] = '{32'hD1000400, 64'h100C, 3'd1, 64'h0000000000000001};
        tbl[4] = '{32'h17FFFFFF, 64'h1010, 3'd3, 64'hFFFFFFFFFFFFFFFC};
        tbl[5] = '{32'hB4000020, 64'h1014, 3'd4, 64'h0000000000000004};
        tbl[6] = '{32'hB5800000, 64'h1018, 3'd4, 64'hFFFFFFFFFFF00000};
        tbl[7] = '{32'h54FFFFE0, 64'h101C, 3'd4, 64'hFFFFFFFFFFFFFFFC};
        tbl[8] = '{32'h8B020020, 64'h1020, 3'd0, 64'h0000000000000000};

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        in_pc     = 64'd0;
        out_ready = 1'b1;
        #12;
        chk_empty("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // back-to-back stream with out_ready=1: count stays 1, head replaced
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, tbl[i].instr, tbl[i].pc);
            step();
            chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d.fmt", i), 64'(out_fmt), 64'(tbl[i].fmt));
            chk($sformatf("vec%0d.imm", i), out_imm, tbl[i].imm);
            chk($sformatf("vec%0d.instr", i), 64'(out_instr),
                64'(tbl[i].instr));
            chk($sformatf("vec%0d.pc", i), out_pc, tbl[i].pc);
        end
        drive(1'b0, 32'd0, 64'd0);
        step();
        chk_empty("drain");

        // backpressure: A, B accepted, C held
        out_ready = 1'b0;
        drive(1'b1, IA, 64'hA0);
        step();
        chk("bp.a_ready", 64'(in_ready), 64'd1);
        drive(1'b1, IB, 64'hB0);
        step();
        chk("bp.full_ready", 64'(in_ready), 64'd0);
        chk("bp.head_a", 64'(out_instr), 64'(IA));
        drive(1'b1, IC, 64'hC0);
        step();
        chk("bp.hold_instr", 64'(out_instr), 64'(IA));
        chk("bp.hold_imm", out_imm, 64'hFFFFFFFFFFFFFFF0);
        chk("bp.hold_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        step();
        chk("bp.out_b", 64'(out_instr), 64'(IB));
        chk("bp.out_b_pc", out_pc, 64'hB0);
        chk("bp.ready_again", 64'(in_ready), 64'd1);
        step();
        chk("bp.out_c", 64'(out_instr), 64'(IC));
        chk("bp.out_c_imm", out_imm, 64'h4);
        chk("bp.out_c_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 32'd0, 64'd0);
        step();
        chk("bp.done_valid", 64'(out_valid), 64'd0);

        // flush at count 2 with an input offered
        out_ready = 1'b0;
        drive(1'b1, IA, 64'hA1);
        step();
        drive(1'b1, IB, 64'hB1);
        step();
        chk("fl.full", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush    = 1'b1;
        in_instr = ID;
        in_pc    = 64'hD1;
        step();
        chk_empty("fl.after");
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl.no_ghost", 64'(out_valid), 64'd0);

        // async reset pulse between edges at count 2
        out_ready = 1'b0;
        drive(1'b1, IA, 64'hA2);
        step();
        drive(1'b1, IB, 64'hB2);
        step();
        chk("rst.full_valid", 64'(out_valid), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_empty("rst.async");
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rst.no_spurious", 64'(out_valid), 64'd0);
        drive(1'b1, IC, 64'hC2);
        step();
        chk("rst.first_valid", 64'(out_valid), 64'd1);
        chk("rst.first_instr", 64'(out_instr), 64'(IC));
        chk("rst.first_pc", out_pc, 64'hC2);
        drive(1'b0, 32'd0, 64'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
